// File: rtl/seg_scan_mux_pkg.sv
// Seven-segment encodings (active-high, a..g = bit 6..0) shared by the
// hex decoder and the scan driver.
package seg_pkg;

  typedef logic [6:0] seg_code_t;

  localparam seg_code_t SEG_0     = 7'h7E;
  localparam seg_code_t SEG_1     = 7'h30;
  localparam seg_code_t SEG_2     = 7'h6D;
  localparam seg_code_t SEG_3     = 7'h79;
  localparam seg_code_t SEG_4     = 7'h33;
  localparam seg_code_t SEG_5     = 7'h5B;
  localparam seg_code_t SEG_6     = 7'h5F;
  localparam seg_code_t SEG_7     = 7'h70;
  localparam seg_code_t SEG_8     = 7'h7F;
  localparam seg_code_t SEG_9     = 7'h7B;
  localparam seg_code_t SEG_A     = 7'h77;
  localparam seg_code_t SEG_B     = 7'h1F;
  localparam seg_code_t SEG_C     = 7'h4E;
  localparam seg_code_t SEG_D     = 7'h3D;
  localparam seg_code_t SEG_E     = 7'h4F;
  localparam seg_code_t SEG_F     = 7'h47;
  localparam seg_code_t SEG_BLANK = 7'h00;

  function automatic seg_code_t hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return SEG_0;
      4'h1:    return SEG_1;
      4'h2:    return SEG_2;
      4'h3:    return SEG_3;
      4'h4:    return SEG_4;
      4'h5:    return SEG_5;
      4'h6:    return SEG_6;
      4'h7:    return SEG_7;
      4'h8:    return SEG_8;
      4'h9:    return SEG_9;
      4'hA:    return SEG_A;
      4'hB:    return SEG_B;
      4'hC:    return SEG_C;
      4'hD:    return SEG_D;
      4'hE:    return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit hex to active-high seven-segment decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output seg_code_t  seg
);

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed multi-digit seven-segment driver: scans a per-frame snapshot
// of hex_in onto one shared segment bus with dead time and selectable polarity.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEAD_CYCLES    = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    blank_lz,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_tick
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0]         PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF    = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF    = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic                    en_d;
  logic [4*NUM_DIGITS-1:0] hex_snap;
  logic [NUM_DIGITS-1:0]   dp_snap;
  logic                    blz_snap;

  logic                    fresh;
  logic                    slot_end;
  logic                    frame_end;
  logic                    in_dead;
  logic [4*NUM_DIGITS-1:0] hex_cur;
  logic [NUM_DIGITS-1:0]   dp_cur;
  logic                    blz_cur;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    above_zero;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   onehot;
  seg_code_t               dec_seg;
  seg_code_t               lit_seg;

  assign fresh     = en & ~en_d;
  assign slot_end  = (presc == PRESC_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign in_dead   = (int'(presc) < DEAD_CYCLES);

  // The first enabled cycle has not captured a snapshot yet, so read the live inputs.
  assign hex_cur = fresh ? hex_in   : hex_snap;
  assign dp_cur  = fresh ? dp_in    : dp_snap;
  assign blz_cur = fresh ? blank_lz : blz_snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (!en) begin
      presc <= '0;
      idx   <= '0;
    end else if (slot_end) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d     <= 1'b0;
      hex_snap <= '0;
      dp_snap  <= '0;
      blz_snap <= 1'b0;
    end else begin
      en_d <= en;
      if (en && (fresh || frame_end)) begin
        hex_snap <= hex_in;
        dp_snap  <= dp_in;
        blz_snap <= blank_lz;
      end
    end
  end

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    above_zero = 1'b1;
    blank_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      above_zero    = above_zero && (hex_cur[4*k +: 4] == 4'h0);
      blank_mask[k] = blz_cur && above_zero && (k != 0);
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    onehot    = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib   = hex_cur[4*k +: 4];
        cur_dp    = dp_cur[k];
        cur_blank = blank_mask[k];
        onehot[k] = 1'b1;
      end
    end
  end

  seg_hex_decode u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  assign lit_seg = cur_blank ? SEG_BLANK : dec_seg;

  // XOR with the off level converts active-high codes to the pin polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      dig_en     <= DIG_OFF;
      frame_tick <= 1'b0;
    end else if (!en) begin
      seg        <= SEG_OFF;
      dp         <= DP_OFF;
      dig_en     <= DIG_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= lit_seg ^ SEG_OFF;
      dp         <= cur_dp ^ DP_OFF;
      dig_en     <= in_dead ? DIG_OFF : (onehot ^ DIG_OFF);
      frame_tick <= (idx == '0) && (presc == '0);
    end
  end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: an active-high and an active-low
// instance share stimulus and are checked every cycle against a frame-position model.
`timescale 1ns/1ps
module tb_seg_scan_mux;

  localparam int N     = 4;
  localparam int S     = 4;
  localparam int DEAD  = 1;
  localparam int FRAME = N * S;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        en       = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] hex_in   = '0;
  logic [3:0]  dp_in    = '0;

  logic [6:0] seg, seg_lo;
  logic       dp, dp_lo;
  logic [3:0] dig_en, dig_en_lo;
  logic       frame_tick, frame_tick_lo;

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  always #5 clk = ~clk;

  seg_scan_mux #(
    .NUM_DIGITS(N), .SCAN_DIV(S), .DEAD_CYCLES(DEAD),
    .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .blank_lz(blank_lz),
    .hex_in(hex_in), .dp_in(dp_in),
    .seg(seg), .dp(dp), .dig_en(dig_en), .frame_tick(frame_tick)
  );

  seg_scan_mux #(
    .NUM_DIGITS(N), .SCAN_DIV(S), .DEAD_CYCLES(DEAD),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut_lo (
    .clk(clk), .rst_n(rst_n), .en(en), .blank_lz(blank_lz),
    .hex_in(hex_in), .dp_in(dp_in),
    .seg(seg_lo), .dp(dp_lo), .dig_en(dig_en_lo), .frame_tick(frame_tick_lo)
  );

  // Model: p counts enabled cycles since scanning (re)started; the slot and phase
  // follow from p, and the frame's digits are latched whenever p crosses a frame.
  logic [6:0]  exp_seg = '0;
  logic        exp_dp  = 1'b0;
  logic [3:0]  exp_dig = '0;
  logic        exp_ft  = 1'b0;
  bit          active  = 1'b0;
  int          p       = 0;
  int          slot, phase;
  logic [15:0] m_hex   = '0;
  logic [3:0]  m_dp    = '0;
  logic        m_blz   = 1'b0;
  logic [3:0]  nib;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !en) begin
      exp_seg = '0;
      exp_dp  = 1'b0;
      exp_dig = '0;
      exp_ft  = 1'b0;
      active  = 1'b0;
    end else begin
      if (!active) begin
        active = 1'b1;
        p      = 0;
        m_hex  = hex_in;
        m_dp   = dp_in;
        m_blz  = blank_lz;
      end
      slot  = (p / S) % N;
      phase = p % S;
      nib   = m_hex[4*slot +: 4];
      if (m_blz && slot != 0 && (m_hex >> (4 * slot)) == 16'h0)
        exp_seg = 7'h00;
      else
        exp_seg = seg_tab[nib];
      exp_dp  = m_dp[slot];
      exp_dig = (phase < DEAD) ? 4'b0000 : 4'(1 << slot);
      exp_ft  = (p % FRAME == 0);
      p++;
      if (p % FRAME == 0) begin
        m_hex = hex_in;
        m_dp  = dp_in;
        m_blz = blank_lz;
      end
    end
  end

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    cmp("model_seg",    {1'b0, seg},            {1'b0, exp_seg});
    cmp("model_dp",     {7'b0, dp},             {7'b0, exp_dp});
    cmp("model_dig",    {4'b0, dig_en},         {4'b0, exp_dig});
    cmp("model_ft",     {7'b0, frame_tick},     {7'b0, exp_ft});
    cmp("model_seg_lo", {1'b0, seg_lo},         {1'b0, ~exp_seg});
    cmp("model_dp_lo",  {7'b0, dp_lo},          {7'b0, ~exp_dp});
    cmp("model_dig_lo", {4'b0, dig_en_lo},      {4'b0, ~exp_dig});
    cmp("model_ft_lo",  {7'b0, frame_tick_lo},  {7'b0, exp_ft});
  end

  // Literal expectations are given in active-high form; the low instance must show the inverse.
  task automatic checkOutput(input string name, input logic [6:0] s, input logic [3:0] d,
                             input logic p_dp, input logic f);
    cmp({name, "_seg"},    {1'b0, seg},           {1'b0, s});
    cmp({name, "_dig"},    {4'b0, dig_en},        {4'b0, d});
    cmp({name, "_dp"},     {7'b0, dp},            {7'b0, p_dp});
    cmp({name, "_ft"},     {7'b0, frame_tick},    {7'b0, f});
    cmp({name, "_seg_lo"}, {1'b0, seg_lo},        {1'b0, ~s});
    cmp({name, "_dig_lo"}, {4'b0, dig_en_lo},     {4'b0, ~d});
    cmp({name, "_dp_lo"},  {7'b0, dp_lo},         {7'b0, ~p_dp});
    cmp({name, "_ft_lo"},  {7'b0, frame_tick_lo}, {7'b0, f});
  endtask

  task automatic applyStimulus(input logic [15:0] h, input logic [3:0] d, input logic b,
                               input logic e);
    @(posedge clk);
    #1;
    hex_in   = h;
    dp_in    = d;
    blank_lz = b;
    en       = e;
  endtask

  task automatic waitNeg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic startFrame(input logic [15:0] h, input logic [3:0] d, input logic b);
    applyStimulus(h, d, b, 1'b0);
    applyStimulus(h, d, b, 1'b1);
  endtask

  initial begin
    $display("[TB] seg_scan_mux bench start");
    waitNeg(2);
    checkOutput("reset_idle", 7'h00, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Plain scan of 1234
    startFrame(16'h1234, 4'b0000, 1'b0);
    waitNeg(2); checkOutput("scan_d0_dead", 7'h33, 4'b0000, 1'b0, 1'b1);
    waitNeg(1); checkOutput("scan_d0",      7'h33, 4'b0001, 1'b0, 1'b0);
    waitNeg(4); checkOutput("scan_d1",      7'h79, 4'b0010, 1'b0, 1'b0);
    waitNeg(4); checkOutput("scan_d2",      7'h6D, 4'b0100, 1'b0, 1'b0);
    waitNeg(4); checkOutput("scan_d3",      7'h30, 4'b1000, 1'b0, 1'b0);
    waitNeg(3); checkOutput("scan_wrap",    7'h33, 4'b0000, 1'b0, 1'b1);
    waitNeg(1); checkOutput("scan_d0_2nd",  7'h33, 4'b0001, 1'b0, 1'b0);

    // Asynchronous reset mid-slot, then restart at digit 0
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("reset_async", 7'h00, 4'b0000, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    waitNeg(2); checkOutput("rst_rel_dead", 7'h33, 4'b0000, 1'b0, 1'b1);
    waitNeg(1); checkOutput("rst_rel_d0",   7'h33, 4'b0001, 1'b0, 1'b0);

    // Leading-zero blanking
    startFrame(16'h0050, 4'b0000, 1'b1);
    waitNeg(3); checkOutput("blz_d0", 7'h7E, 4'b0001, 1'b0, 1'b0);
    waitNeg(4); checkOutput("blz_d1", 7'h5B, 4'b0010, 1'b0, 1'b0);
    waitNeg(4); checkOutput("blz_d2", 7'h00, 4'b0100, 1'b0, 1'b0);
    waitNeg(4); checkOutput("blz_d3", 7'h00, 4'b1000, 1'b0, 1'b0);
    startFrame(16'h0000, 4'b0000, 1'b1);
    waitNeg(3); checkOutput("blz0_d0", 7'h7E, 4'b0001, 1'b0, 1'b0);
    waitNeg(4); checkOutput("blz0_d1", 7'h00, 4'b0010, 1'b0, 1'b0);

    // Snapshot holds for the whole frame
    startFrame(16'h1111, 4'b0000, 1'b0);
    waitNeg(7); checkOutput("snap_d1", 7'h30, 4'b0010, 1'b0, 1'b0);
    applyStimulus(16'h2222, 4'b0000, 1'b0, 1'b1);
    waitNeg(4); checkOutput("snap_d2_old", 7'h30, 4'b0100, 1'b0, 1'b0);
    waitNeg(4); checkOutput("snap_d3_old", 7'h30, 4'b1000, 1'b0, 1'b0);
    waitNeg(3); checkOutput("snap_wrap",   7'h6D, 4'b0000, 1'b0, 1'b1);
    waitNeg(1); checkOutput("snap_d0_new", 7'h6D, 4'b0001, 1'b0, 1'b0);
    waitNeg(8); checkOutput("snap_d2_new", 7'h6D, 4'b0100, 1'b0, 1'b0);

    // Enable drop and restart
    applyStimulus(16'h2222, 4'b0000, 1'b0, 1'b0);
    waitNeg(2); checkOutput("en_off", 7'h00, 4'b0000, 1'b0, 1'b0);
    applyStimulus(16'h2222, 4'b0000, 1'b0, 1'b1);
    waitNeg(2); checkOutput("en_on_dead", 7'h6D, 4'b0000, 1'b0, 1'b1);
    waitNeg(1); checkOutput("en_on_d0",   7'h6D, 4'b0001, 1'b0, 1'b0);

    // Decimal point on a blanked digit
    startFrame(16'h0000, 4'b0100, 1'b1);
    waitNeg(3); checkOutput("dp_d0", 7'h7E, 4'b0001, 1'b0, 1'b0);
    waitNeg(4); checkOutput("dp_d1", 7'h00, 4'b0010, 1'b0, 1'b0);
    waitNeg(4); checkOutput("dp_d2", 7'h00, 4'b0100, 1'b1, 1'b0);
    waitNeg(4); checkOutput("dp_d3", 7'h00, 4'b1000, 1'b0, 1'b0);

    waitNeg(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
